// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a 1-cycle-latency synchronous FIFO into a valid/ready stream
// through a 2-entry skid buffer. Define FIFO_RD_STATS_EN to add the words_cnt counter.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_underflow
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  words_cnt
`endif
);

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [FIFO_WIDTH-1:0] r_head;
  logic [FIFO_WIDTH-1:0] r_tail;
  logic                  r_err;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop_uf;
  logic [2:0]            w_credit_used;

  assign m_valid       = (r_occ != 2'd0);
  assign m_data        = r_head;
  assign err_underflow = r_err;

  assign w_pop     = m_valid & m_ready;
  assign w_push    = r_inflight & ~flush & ~fifo_underflow;
  assign w_drop_uf = r_inflight & ~flush & fifo_underflow;

  // Entries already owned by the buffer once this cycle settles; a new read is
  // only issued when its word is guaranteed a free slot on arrival.
  assign w_credit_used = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_rd_en    = ~rst & enable & ~flush & ~fifo_empty & (w_credit_used < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else if (flush) begin
      r_occ  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b01: begin
          r_head <= r_tail;
          r_tail <= '0;
          r_occ  <= r_occ - 2'd1;
        end
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head <= fifo_data_out;
          end else begin
            r_tail <= fifo_data_out;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the arriving word goes behind whatever remains.
          if (r_occ == 2'd1) begin
            r_head <= fifo_data_out;
          end else begin
            r_head <= r_tail;
            r_tail <= fifo_data_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_drop_uf) begin
      r_err <= 1'b1;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] r_words_cnt;

  // A flush discards the buffer, so a handshake in that cycle is not a delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_words_cnt <= '0;
    end else if (w_pop & ~flush) begin
      r_words_cnt <= r_words_cnt + CNT_WIDTH'(1);
    end
  end

  assign words_cnt = r_words_cnt;
`else
  if (CNT_WIDTH > 0) begin : g_no_stats
  end
`endif

endmodule
